// File: rtl/ee354_seqlock_pkg.sv
// ee354_seqlock_pkg
//   Shared definitions for the button-sequence lock:
//   - state_t   : state encoding, also driven out as the 3-bit state_code
//   - clog2/max2: width helpers usable in parameter expressions
//   - SSD_*     : seven-segment patterns (active-low, gfedcba) that a board
//                 top level uses to show the state number, plus a mapper.
package ee354_seqlock_pkg;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_OPENING = 3'd2,
    ST_BAD     = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam logic [6:0] SSD_ST_WAIT    = 7'b1000000;  // "0"
  localparam logic [6:0] SSD_ST_PRESS   = 7'b1111001;  // "1"
  localparam logic [6:0] SSD_ST_OPENING = 7'b0100100;  // "2"
  localparam logic [6:0] SSD_ST_BAD     = 7'b0110000;  // "3"
  localparam logic [6:0] SSD_ST_LOCKOUT = 7'b0011001;  // "4"
  localparam logic [6:0] SSD_BLANK      = 7'b1111111;

  function automatic logic [6:0] state_to_ssd(input logic [2:0] s);
    logic [6:0] seg;
    case (s)
      3'd0:    seg = SSD_ST_WAIT;
      3'd1:    seg = SSD_ST_PRESS;
      3'd2:    seg = SSD_ST_OPENING;
      3'd3:    seg = SSD_ST_BAD;
      3'd4:    seg = SSD_ST_LOCKOUT;
      default: seg = SSD_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ee354_seqlock_timer.sv
// ee354_seqlock_timer
//   Loadable down-counter that stops at zero. One instance is shared by
//   the OPENING and LOCKOUT windows.
//   clk      : clock
//   reset_n  : asynchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one unless already zero
//   zero     : count is zero
module ee354_seqlock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/ee354_seqlock_core.sv
// ee354_seqlock_core
//   Button-sequence lock. U/Z presses (each followed by a release) are
//   compared MSB-first against a CODE_LEN-bit code (1 = U, 0 = Z). A correct
//   sequence opens the lock for OPEN_CYCLES clocks; MAX_BAD consecutive bad
//   attempts cause a LOCKOUT_CYCLES lockout.
//   clk        : clock (divided domain)
//   reset_n    : asynchronous active-low reset
//   U, Z       : button levels, synchronous to clk
//   code_in    : new code value
//   code_load  : code load request
//   unlock     : high in OPENING
//   lockout    : high in LOCKOUT
//   state_code : current state number (debug / SSD)
//   digit_idx  : digits accepted in the current attempt
//   bad_count  : consecutive bad attempts
//   load_ack   : one-cycle pulse after a code load is accepted
//
// Code-load handshake: code_load is a level request sampled every clock.
// It is accepted only in WAIT with digit_idx == 0 and no button pressed;
// on the accepting edge the code register takes code_in and load_ack is
// high for the following cycle. A request that is not accepted is dropped
// without an ack and the requester must keep or re-issue it. A button
// press in the same cycle blocks acceptance.
module ee354_seqlock_core
  import ee354_seqlock_pkg::*;
#(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE_RST       = 4'b1011,
  parameter int                  MAX_BAD        = 3,
  parameter int                  OPEN_CYCLES    = 8,
  parameter int                  LOCKOUT_CYCLES = 16,
  localparam int                 DW             = clog2(CODE_LEN),
  localparam int                 BW             = clog2(MAX_BAD + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                U,
  input  logic                Z,
  input  logic [CODE_LEN-1:0] code_in,
  input  logic                code_load,
  output logic                unlock,
  output logic                lockout,
  output logic [2:0]          state_code,
  output logic [DW-1:0]       digit_idx,
  output logic [BW-1:0]       bad_count,
  output logic                load_ack
);

  // At least one bit so a 1-cycle window for both timers still elaborates.
  localparam int TW = max2(1, clog2(max2(OPEN_CYCLES, LOCKOUT_CYCLES)));

  state_t              r_state;
  logic [DW-1:0]       r_digit;
  logic [BW-1:0]       r_bad;
  logic [CODE_LEN-1:0] r_code;
  logic                r_ack;

  state_t              w_state_nxt;
  logic [DW-1:0]       w_digit_nxt;
  logic [BW-1:0]       w_bad_nxt;
  logic [CODE_LEN-1:0] w_code_nxt;
  logic                w_ack_nxt;
  logic                w_tmr_load;
  logic [TW-1:0]       w_tmr_val;
  logic                w_tmr_dec;
  logic                w_tmr_zero;

  logic                w_exp;
  logic                w_any;
  logic                w_hit;
  logic                w_other;
  logic                w_last;
  logic [BW-1:0]       w_bad_inc;

  // Expected digit: code[CODE_LEN-1-digit_idx].
  always_comb begin
    w_exp = 1'b0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (DW'(CODE_LEN - 1 - i) == r_digit) w_exp = r_code[i];
    end
  end

  assign w_any     = U | Z;
  assign w_hit     = w_exp ? U : Z;  // the button that matches exp
  assign w_other   = w_exp ? Z : U;  // the button that does not
  assign w_last    = (r_digit == DW'(CODE_LEN - 1));
  assign w_bad_inc = (r_bad == BW'(MAX_BAD)) ? r_bad : r_bad + 1'b1;

  ee354_seqlock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .dec      (w_tmr_dec),
    .zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_bad_nxt   = r_bad;
    w_code_nxt  = r_code;
    w_ack_nxt   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;

    case (r_state)
      ST_WAIT: begin
        if (U && Z) begin
          w_state_nxt = ST_BAD;
        end else if (w_any) begin
          w_state_nxt = w_hit ? ST_PRESS : ST_BAD;
        end else if (code_load && (r_digit == '0)) begin
          w_code_nxt = code_in;
          w_ack_nxt  = 1'b1;
          w_bad_nxt  = '0;
        end
      end

      ST_PRESS: begin
        // Digit is unchanged while in PRESS, so exp still names the held
        // button; any activity on the other button is an error.
        if (w_other) begin
          w_state_nxt = ST_BAD;
        end else if (!w_any) begin
          if (w_last) begin
            w_state_nxt = ST_OPENING;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(OPEN_CYCLES - 1);
            w_digit_nxt = '0;
            w_bad_nxt   = '0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_digit_nxt = r_digit + 1'b1;
          end
        end
      end

      ST_OPENING: begin
        w_tmr_dec = 1'b1;
        if (w_tmr_zero) w_state_nxt = ST_WAIT;
      end

      ST_BAD: begin
        if (!w_any) begin
          w_digit_nxt = '0;
          w_bad_nxt   = w_bad_inc;
          if (w_bad_inc == BW'(MAX_BAD)) begin
            w_state_nxt = ST_LOCKOUT;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end

      ST_LOCKOUT: begin
        // Timer sits at zero while a button is still held.
        w_tmr_dec = 1'b1;
        if (w_tmr_zero && !w_any) begin
          w_state_nxt = ST_WAIT;
          w_bad_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = ST_WAIT;
        w_digit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_WAIT;
      r_digit <= '0;
      r_bad   <= '0;
      r_code  <= CODE_RST;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_bad   <= w_bad_nxt;
      r_code  <= w_code_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign unlock     = (r_state == ST_OPENING);
  assign lockout    = (r_state == ST_LOCKOUT);
  assign state_code = r_state;
  assign digit_idx  = r_digit;
  assign bad_count  = r_bad;
  assign load_ack   = r_ack;

endmodule

// File: doc/ee354_seqlock_core.md
Name: ee354_seqlock_core

Overview:
- Parametrised successor to the fixed 1011 button-sequence lock FSM.
- Accepts a sequence of U/Z button presses, each followed by a release, and compares it against a CODE_LEN-bit code. The code is either fixed at reset or runtime-loadable.
- Holds `unlock` for a timed opening window. After MAX_BAD consecutive failed attempts it enters a timed lockout.
- Sits between the button/clock-divider logic and the LED/SSD display logic in a board top level.

Parameters:
- CODE_LEN, 4, number of code digits (2..16). MSB is entered first.
- CODE_RST, 4'b1011, code loaded at reset; width CODE_LEN; 1 = U, 0 = Z.
- MAX_BAD, 3, consecutive bad attempts that trigger lockout (1..15).
- OPEN_CYCLES, 8, clk cycles that `unlock` stays high (≥1).
- LOCKOUT_CYCLES, 16, clk cycles of lockout (≥1).

Ports:
- clk  in  1  system clock (divided clock domain).
- reset_n  in  1  asynchronous, active-low reset.
- U  in  1  "one" button, level, already synchronous to clk.
- Z  in  1  "zero" button, level, already synchronous to clk.
- code_in  in  CODE_LEN  new code value.
- code_load  in  1  load request for code_in.
- unlock  out  1  high in OPENING.
- lockout  out  1  high in LOCKOUT.
- state_code  out  3  current state number.
- digit_idx  out  clog2(CODE_LEN)  number of digits accepted so far in this attempt.
- bad_count  out  clog2(MAX_BAD+1)  consecutive bad attempts.
- load_ack  out  1  one-cycle pulse when a code load is accepted.

Behaviour:
- Registers: state, digit_idx, bad_count, timer, code register, load_ack.
  - All flops use asynchronous, active-low reset.
  - Reset values: state = WAIT, digit_idx = 0, bad_count = 0, timer = 0, code = CODE_RST, load_ack = 0.
  - Resulting output values at reset: unlock = 0, lockout = 0, state_code = 0.
- States (state_code): WAIT = 0, PRESS = 1, OPENING = 2, BAD = 3, LOCKOUT = 4. Codes 5..7 are illegal and go to WAIT with digit_idx = 0 on the next clk.
- Expected digit: exp = code[CODE_LEN-1-digit_idx].
- WAIT:
  - U & Z both high → BAD.
  - Exactly one button high and it matches exp (U for 1, Z for 0) → PRESS.
  - Exactly one button high and it does not match exp → BAD.
  - Neither high → stay.
- PRESS:
  - The non-pressed button also goes high → BAD.
  - Both buttons low, digit_idx == CODE_LEN-1 → OPENING; timer = OPEN_CYCLES-1; digit_idx = 0; bad_count = 0.
  - Both buttons low, otherwise → WAIT; digit_idx + 1.
  - Pressed button still held → stay.
- OPENING:
  - unlock = 1; inputs are ignored.
  - timer decrements each cycle. When timer == 0 → WAIT, so unlock is high for exactly OPEN_CYCLES cycles.
- BAD:
  - Stay until U = Z = 0. Then digit_idx = 0 and bad_count + 1.
  - If the new bad_count == MAX_BAD → LOCKOUT with timer = LOCKOUT_CYCLES-1; otherwise → WAIT.
  - bad_count saturates at MAX_BAD.
- LOCKOUT:
  - lockout = 1; inputs are ignored.
  - When timer == 0 and U = Z = 0 → WAIT with bad_count = 0.
  - When timer == 0 with a button held → stay with timer held at 0.
- Code load:
  - Accepted only when code_load = 1, state == WAIT, digit_idx == 0 and U = Z = 0.
  - On acceptance: code = code_in next edge, load_ack = 1 for one cycle, bad_count = 0.
  - Otherwise the request is ignored with no ack (the requester retries).
  - A code_load in the same cycle as a button press: the press wins, the load is ignored.
- Timer width: clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)). The timer never underflows.
- Reset asserted mid-sequence aborts the attempt immediately (asynchronous) and restores the code to CODE_RST.

Decomposition:
- Shared package ee354_seqlock_pkg:
  - state localparams ST_WAIT..ST_LOCKOUT (3-bit);
  - a clog2 function;
  - the state-number-to-SSD digit mapping constants reused by the top level.
- Sub-module ee354_seqlock_timer:
  - ports: clk, reset_n, load, load_val, dec, zero;
  - a down-counter that saturates at 0;
  - instantiated once and shared by OPENING and LOCKOUT.

Test Plan:
1. Default code: reset, then press/release U, Z, U, U (each held 2 cycles) → digit_idx steps 1, 2, 3; unlock high for exactly 8 cycles; state_code returns to 0.
2. Wrong digit: U, then U again where Z is expected → state_code = 3 while held; after release bad_count = 1, digit_idx = 0, WAIT.
3. Lockout: three bad attempts → lockout = 1 for 16 cycles. A correct sequence entered during lockout is ignored. After lockout, bad_count = 0.
4. Simultaneous buttons: U & Z high in WAIT → BAD. Z going high while U held in PRESS → BAD.
5. Code load: code_load with code_in = 4'b0110 in idle → load_ack pulses once. Z, U, U, Z → unlock. The old sequence 1011 → BAD. code_load issued while digit_idx = 2 → no ack, code unchanged.
6. Async reset: assert reset_n = 0 mid-OPENING, between clk edges → unlock = 0 immediately; code restored to 1011. Also test CODE_LEN = 6, CODE_RST = 6'b110010 and confirm a 6-digit unlock.
